// File: rtl/mem_handshake_seq_if.sv
// Bus bundle between the control unit, the memory-access sequencer and RAM.
// master = sequencer side, slave = CU/RAM side.
interface mem_handshake_seq_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic                  i_req;
    logic                  i_rw;
    logic [1:0]            i_size;
    logic                  i_sx;
    logic [ADDR_W-1:0]     i_addr;
    logic [DATA_W-1:0]     i_wdata;
    logic                  i_moc;
    logic [DATA_W-1:0]     i_mem_rdata;
    logic                  o_mov;
    logic                  o_mem_rw;
    logic [ADDR_W-1:0]     o_mem_addr;
    logic [DATA_W-1:0]     o_mem_wdata;
    logic [DATA_W/8-1:0]   o_be;
    logic [DATA_W-1:0]     o_rdata;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_err;
    logic [1:0]            o_err_code;

    modport master (
        input  i_req, i_rw, i_size, i_sx, i_addr, i_wdata, i_moc, i_mem_rdata,
        output o_mov, o_mem_rw, o_mem_addr, o_mem_wdata, o_be, o_rdata,
        output o_busy, o_done, o_err, o_err_code
    );

    modport slave (
        output i_req, i_rw, i_size, i_sx, i_addr, i_wdata, i_moc, i_mem_rdata,
        input  o_mov, o_mem_rw, o_mem_addr, o_mem_wdata, o_be, o_rdata,
        input  o_busy, o_done, o_err, o_err_code
    );
endinterface

// File: rtl/mem_handshake_seq.sv
// Memory-access sequencer: runs the 4-phase MOV/MOC handshake, builds byte enables,
// replicates write data and aligns/extends read data; flags misalignment and MOC timeout.
module mem_handshake_seq #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                i_clk,
    input  logic                i_clr,
    mem_handshake_seq_if.master bus
);
    localparam int unsigned LANES  = DATA_W / 8;
    localparam int unsigned LANE_W = $clog2(LANES);
    localparam int unsigned SH_W   = $clog2(DATA_W);
    localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {StIdle, StAssert, StDone, StRelease, StErr} state_t;

    state_t                     r_state, w_state_next;
    logic                       r_rw;
    logic [1:0]                 r_size;
    logic                       r_sx;
    logic [ADDR_W-1:0]          r_addr;
    logic [LANES-1:0]           r_be;
    logic [DATA_W-1:0]          r_mem_wdata;
    logic [DATA_W-1:0]          r_rdata;
    logic [1:0]                 r_err_code;
    logic [CNT_W-1:0]           r_cnt;

    logic [3:0]                 w_bytes_in;
    logic [LANE_W-1:0]          w_lane_in;
    logic [LANE_W-1:0]          w_align_mask;
    logic                       w_size_ok;
    logic                       w_req_ok;
    logic [LANES-1:0]           w_be_in;
    logic [LANES-1:0][7:0]      w_wbytes;
    logic [DATA_W-1:0]          w_wdata_rep;
    logic [DATA_W-1:0]          w_rd_shift;
    logic [SH_W-1:0]            w_msb_idx;
    logic                       w_sign;
    logic [DATA_W-1:0]          w_rd_ext;
    logic                       w_timeout;

    // Request decode: lane, alignment and byte enables come straight from the CU inputs.
    assign w_bytes_in   = 4'd1 << bus.i_size;
    assign w_lane_in    = bus.i_addr[LANE_W-1:0];
    assign w_align_mask = LANE_W'(w_bytes_in - 4'd1);
    assign w_size_ok    = (bus.i_size != 2'b11) || (DATA_W == 64);
    assign w_req_ok     = w_size_ok && ((w_lane_in & w_align_mask) == '0);
    assign w_be_in      = LANES'((16'd1 << w_bytes_in) - 16'd1) << w_lane_in;
    assign w_wbytes     = bus.i_wdata;

    // Lane i takes source byte (i mod bytes), replicating the low access-sized chunk.
    always_comb begin
        w_wdata_rep = '0;
        for (int i = 0; i < LANES; i++) begin
            w_wdata_rep[8*i +: 8] = w_wbytes[LANE_W'(i) & w_align_mask];
        end
    end

    always_comb begin
        w_rd_shift = bus.i_mem_rdata >> {r_addr[LANE_W-1:0], 3'b000};
        unique case (r_size)
            2'b00:   w_msb_idx = SH_W'(7);
            2'b01:   w_msb_idx = SH_W'(15);
            2'b10:   w_msb_idx = SH_W'(31);
            default: w_msb_idx = SH_W'(DATA_W - 1);
        endcase
        w_sign = r_sx & w_rd_shift[w_msb_idx];
        w_rd_ext = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_rd_ext[i] = (i <= int'(w_msb_idx)) ? w_rd_shift[i] : w_sign;
        end
    end

    assign w_timeout = (TIMEOUT != 0) && (r_cnt == TO_CNT);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:    if (bus.i_req) w_state_next = w_req_ok ? StAssert : StErr;
            StAssert: begin
                if (bus.i_moc)      w_state_next = StDone;
                else if (w_timeout) w_state_next = StErr;
            end
            StDone:    w_state_next = StRelease;
            StRelease: if (!bus.i_moc) w_state_next = StIdle;
            StErr:     w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) r_state <= StIdle;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_rw        <= 1'b0;
            r_size      <= 2'b00;
            r_sx        <= 1'b0;
            r_addr      <= '0;
            r_be        <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_err_code  <= 2'b00;
            r_cnt       <= '0;
        end else begin
            if (r_state == StIdle && bus.i_req) begin
                r_rw        <= bus.i_rw;
                r_size      <= bus.i_size;
                r_sx        <= bus.i_sx;
                r_addr      <= bus.i_addr;
                r_be        <= w_be_in;
                r_mem_wdata <= w_wdata_rep;
                r_err_code  <= w_req_ok ? 2'b00 : 2'b01;
                r_cnt       <= '0;
            end
            if (r_state == StAssert) begin
                if (bus.i_moc) begin
                    if (r_rw) r_rdata <= w_rd_ext;
                end else if (w_timeout) begin
                    r_err_code <= 2'b10;
                end else if (TIMEOUT != 0) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    // Handshake strobes decode the state register, so CLR drops them without a clock.
    assign bus.o_mov       = (r_state == StAssert);
    assign bus.o_busy      = (r_state != StIdle);
    assign bus.o_done      = (r_state == StDone);
    assign bus.o_err       = (r_state == StErr);
    assign bus.o_mem_rw    = r_rw;
    assign bus.o_mem_addr  = {r_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
    assign bus.o_mem_wdata = r_mem_wdata;
    assign bus.o_be        = r_be;
    assign bus.o_rdata     = r_rdata;
    assign bus.o_err_code  = r_err_code;
endmodule
